// File: rtl/alu_share_ctrl_pkg.sv
// alu_share_ctrl_pkg: shared types and constants for the time-shared ALU controller.
package alu_share_ctrl_pkg;

    localparam int DATA_W  = 32;
    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0011;
    localparam logic [3:0] OP_OR  = 4'b0100;
    localparam logic [3:0] OP_SLL = 4'b0101;
    localparam logic [3:0] OP_SRL = 4'b0110;

endpackage

// File: rtl/alu_share_ctrl_if.sv
// alu_share_ctrl_if: per-port request/response channels between requesters and the controller.
interface alu_share_ctrl_if;
    import alu_share_ctrl_pkg::*;

    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ-1:0]             req_ready;
    logic [NUM_REQ-1:0][DATA_W-1:0] req_a;
    logic [NUM_REQ-1:0][DATA_W-1:0] req_b;
    logic [NUM_REQ-1:0][3:0]        req_ctrl;
    logic [NUM_REQ-1:0]             rsp_valid;
    logic [NUM_REQ-1:0]             rsp_ready;
    logic [DATA_W-1:0]              rsp_result;
    logic                           rsp_zero;

    modport master (
        output req_valid, req_a, req_b, req_ctrl, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_zero
    );

    modport slave (
        input  req_valid, req_a, req_b, req_ctrl, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_zero
    );

endinterface

// File: rtl/alu_share_arb.sv
// alu_share_arb: combinational 2-way picker, round-robin on rr.
// ALU_SHARE_FIXED_PRIO_EN selects fixed priority with port 0 first and rr ignored.
module alu_share_arb (
    input  logic [1:0] valid,
    input  logic       rr,
    output logic       winner,
    output logic       grant_valid
);

    assign grant_valid = |valid;
`ifdef ALU_SHARE_FIXED_PRIO_EN
    logic unused_rr;
    assign unused_rr = rr;
    assign winner    = ~valid[0];
`else
    // The pointed-to port keeps the grant whenever it is requesting.
    assign winner = valid[rr] ? rr : ~rr;
`endif

endmodule

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: arbitrates two requesters onto one combinational ALU, IDLE -> EXEC -> RESP.
// ALU_SHARE_FIXED_PRIO_EN removes the round-robin pointer in favour of port 0 priority.
module alu_share_ctrl
    import alu_share_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    alu_share_ctrl_if.slave   bus,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_ctrl,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              busy,
    output logic              owner
);

    state_t            state;
    state_t            state_n;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [3:0]        ctrl_q;
    logic              owner_q;
    logic [DATA_W-1:0] res_q;
    logic              zero_q;
    logic              rr;
    logic              winner;
    logic              grant_valid;
    logic              accept;
    logic              done;

    alu_share_arb u_arb (
        .valid       (bus.req_valid),
        .rr          (rr),
        .winner      (winner),
        .grant_valid (grant_valid)
    );

    always_comb begin
        accept        = (state == IDLE) && grant_valid;
        done          = (state == RESP) && bus.rsp_ready[owner_q];
        state_n       = IDLE;
        state_n       = accept ? EXEC : (state == EXEC) ? RESP : (state == RESP && !done) ? RESP : IDLE;
        bus.req_ready = accept ? (2'b01 << winner) : 2'b00;
        bus.rsp_valid = (state == RESP) ? (2'b01 << owner_q) : 2'b00;
        alu_a         = (state == EXEC) ? a_q : '0;
        alu_b         = (state == EXEC) ? b_q : '0;
        alu_ctrl      = (state == EXEC) ? ctrl_q : 4'b0000;
    end

    assign bus.rsp_result = res_q;
    assign bus.rsp_zero   = zero_q;
    assign busy           = (state != IDLE);
    assign owner          = owner_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            ctrl_q  <= 4'b0000;
            owner_q <= 1'b0;
            res_q   <= '0;
            zero_q  <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                a_q     <= bus.req_a[winner];
                b_q     <= bus.req_b[winner];
                ctrl_q  <= bus.req_ctrl[winner];
                owner_q <= winner;
            end
            if (state == EXEC) begin
                res_q  <= alu_result;
                zero_q <= alu_zero;
            end
        end
    end

`ifdef ALU_SHARE_FIXED_PRIO_EN
    assign rr = 1'b0;
`else
    // After serving a port, the other one is next in line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rr <= 1'b0;
        else if (done)
            rr <= ~owner_q;
    end
`endif

endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: directed vectors with hand-computed results for alu_share_ctrl.
module tb_alu_share_ctrl;
    import alu_share_ctrl_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [3:0]        alu_ctrl;
    logic [DATA_W-1:0] alu_result;
    logic              alu_zero;
    logic              busy;
    logic              owner;
    int                checks = 0;
    int                errors = 0;

    alu_share_ctrl_if bus ();

    alu_share_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.slave),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .busy       (busy),
        .owner      (owner)
    );

    always #5 clk = ~clk;

    always_comb begin
        alu_result = '0;
        case (alu_ctrl)
            OP_ADD:  alu_result = alu_a + alu_b;
            OP_SUB:  alu_result = alu_a - alu_b;
            OP_XOR:  alu_result = alu_a ^ alu_b;
            OP_AND:  alu_result = alu_a & alu_b;
            OP_OR:   alu_result = alu_a | alu_b;
            OP_SLL:  alu_result = alu_a << alu_b[4:0];
            OP_SRL:  alu_result = alu_a >> alu_b[4:0];
            default: alu_result = '0;
        endcase
        alu_zero = (alu_result == '0);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        chk({tag, "_rsp_result"}, bus.rsp_result, 32'd0);
        chk({tag, "_rsp_zero"}, 32'(bus.rsp_zero), 32'd0);
        chk({tag, "_alu_a"}, alu_a, 32'd0);
        chk({tag, "_alu_b"}, alu_b, 32'd0);
        chk({tag, "_alu_ctrl"}, 32'(alu_ctrl), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_owner"}, 32'(owner), 32'd0);
    endtask

    task automatic set_req(input int p, input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
        bus.req_valid[p] = 1'b1;
        bus.req_a[p]     = a;
        bus.req_b[p]     = b;
        bus.req_ctrl[p]  = c;
    endtask

    // Expects port p to be granted now and its response after two edges, with rsp_ready high.
    task automatic serve(input int p, input logic [31:0] a, input logic [3:0] c, input logic [31:0] res, input logic z);
        logic [1:0] m;
        m = 2'b01 << p;
        #1;
        chk("grant", 32'(bus.req_ready), 32'(m));
        @(posedge clk); #1;
        bus.req_valid[p] = 1'b0;
        chk("owner", 32'(owner), 32'(p));
        chk("exec_busy", 32'(busy), 32'd1);
        chk("exec_ready", 32'(bus.req_ready), 32'd0);
        chk("exec_alu_a", alu_a, a);
        chk("exec_alu_ctrl", 32'(alu_ctrl), 32'(c));
        @(posedge clk); #1;
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(m));
        chk("rsp_result", bus.rsp_result, res);
        chk("rsp_zero", 32'(bus.rsp_zero), 32'(z));
        chk("resp_alu_a", alu_a, 32'd0);
        @(posedge clk); #1;
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout checks %0d errors %0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_ctrl  = '0;
        bus.rsp_ready = 2'b11;
        repeat (2) @(posedge clk);
        #1;
        chk_idle_outs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        // Both ports from reset: rr=0 so port 0 first in either build.
        set_req(0, 32'd7, 32'd7, OP_SUB);
        set_req(1, 32'd1, 32'd4, OP_SLL);
        serve(0, 32'd7, OP_SUB, 32'd0, 1'b1);
        serve(1, 32'd1, OP_SLL, 32'd16, 1'b0);
        // Single port 0 add, leaves rr pointing at port 1.
        set_req(0, 32'd5, 32'd3, OP_ADD);
        serve(0, 32'd5, OP_ADD, 32'd8, 1'b0);
        set_req(0, 32'd7, 32'd7, OP_SUB);
        set_req(1, 32'd1, 32'd4, OP_SLL);
`ifdef ALU_SHARE_FIXED_PRIO_EN
        serve(0, 32'd7, OP_SUB, 32'd0, 1'b1);
        serve(1, 32'd1, OP_SLL, 32'd16, 1'b0);
`else
        serve(1, 32'd1, OP_SLL, 32'd16, 1'b0);
        serve(0, 32'd7, OP_SUB, 32'd0, 1'b1);
`endif
        // Back-pressure with only the non-owner's rsp_ready high, port 1 pending.
        bus.rsp_ready = 2'b10;
        set_req(0, 32'hFFFF0000, 32'h0F0F0F0F, OP_XOR);
        #1;
        chk("bp_grant", 32'(bus.req_ready), 32'b01);
        @(posedge clk); #1;
        bus.req_valid[0] = 1'b0;
        set_req(1, 32'd1, 32'd1, OP_ADD);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'b01);
            chk("bp_result", bus.rsp_result, 32'hF0F00F0F);
            chk("bp_zero", 32'(bus.rsp_zero), 32'd0);
            chk("bp_no_ready", 32'(bus.req_ready), 32'd0);
            @(posedge clk); #1;
        end
        bus.rsp_ready = 2'b01;
        @(posedge clk); #1;
        chk("bp_released", 32'(bus.rsp_valid), 32'd0);
        bus.rsp_ready = 2'b11;
        serve(1, 32'd1, OP_ADD, 32'd2, 1'b0);
        // Unassigned op code.
        set_req(0, 32'd123, 32'd456, 4'b1010);
        serve(0, 32'd123, 4'b1010, 32'd0, 1'b1);
        // Async reset while port 1 is in EXEC.
        set_req(1, 32'd10, 32'd20, OP_ADD);
        #1;
        chk("rst_grant", 32'(bus.req_ready), 32'b10);
        @(posedge clk); #1;
        bus.req_valid[1] = 1'b0;
        chk("rst_exec_owner", 32'(owner), 32'd1);
        chk("rst_exec_alu_a", alu_a, 32'd10);
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle_outs("rst_async");
        @(posedge clk); #1;
        chk_idle_outs("rst_held");
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
        chk("rst_no_busy", 32'(busy), 32'd0);
        set_req(0, 32'd9, 32'd4, OP_SUB);
        set_req(1, 32'hF0, 32'h0F, OP_OR);
        serve(0, 32'd9, OP_SUB, 32'd5, 1'b0);
        serve(1, 32'hF0, OP_OR, 32'hFF, 1'b0);
        // Port 1 withdraws before any edge accepts it.
        set_req(1, 32'd3, 32'd3, OP_AND);
        #1;
        chk("wd_grant", 32'(bus.req_ready), 32'b10);
        bus.req_valid[1] = 1'b0;
        #1;
        chk("wd_ready", 32'(bus.req_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("wd_busy", 32'(busy), 32'd0);
            chk("wd_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
